// File: rtl/muldiv_if.sv
// muldiv_if: bundles the EX-stage HI/LO op request, the MF stall handshake,
// the HI/LO read-out, the multiplier/divider handshakes and status flags.
//   master : the HI/LO controller (drives stall, hi/lo, unit starts/operands, status)
//   slave  : the environment (EX stage and the two arithmetic units)
interface muldiv_if;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        mf_req;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        mul_start;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic        mul_finish;
  logic [63:0] mul_z;
  logic        div_start;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic        div_finish;
  logic [31:0] div_q;
  logic [31:0] div_r;
  logic        busy;
  logic        dz_flag;
  logic        err;

  modport master (
    input  op_valid, op, rs_val, rt_val, mf_req,
           mul_finish, mul_z, div_finish, div_q, div_r,
    output stall_req, hi, lo, mul_start, mul_a, mul_b,
           div_start, div_a, div_b, busy, dz_flag, err
  );

  modport slave (
    output op_valid, op, rs_val, rt_val, mf_req,
           mul_finish, mul_z, div_finish, div_q, div_r,
    input  stall_req, hi, lo, mul_start, mul_a, mul_b,
           div_start, div_a, div_b, busy, dz_flag, err
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequences a shared unsigned multiplier and unsigned divider,
// owns HI/LO, and applies sign pre/post correction for MULT/DIV.
// Ports:
//   clk    clock
//   reset  asynchronous active-high reset
//   bus    muldiv_if.master (EX request, stall, hi/lo, unit handshakes, status)
//
// state | meaning
// IDLE  | accept MT*/MULT*/DIV* ops, no stall
// ISSUE | one-cycle start pulse to the selected unit
// WAIT  | count down until the selected unit finishes or the timer expires
// WB    | sign-correct the latched result and write HI/LO
module muldiv_ctrl #(
  parameter int TIMEOUT = 64
) (
  input logic      clk,
  input logic      reset,
  muldiv_if.master bus
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WB} state_t;

  state_t          state_q, state_d;
  logic            is_div_q, is_div_d;
  logic            sa_q, sa_d;
  logic            sb_q, sb_d;
  logic [31:0]     a_q, a_d;
  logic [31:0]     b_q, b_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [63:0]     res_q, res_d;
  logic [31:0]     hi_q, hi_d;
  logic [31:0]     lo_q, lo_d;
  logic            dz_q, dz_d;
  logic            err_q, err_d;

  logic            neg_a, neg_b, sel_finish;

  // op[0] clear means signed (MULT=0, DIV=2)
  assign neg_a      = ~bus.op[0] & bus.rs_val[31];
  assign neg_b      = ~bus.op[0] & bus.rt_val[31];
  assign sel_finish = is_div_q ? bus.div_finish : bus.mul_finish;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      is_div_q <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      res_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      dz_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      is_div_q <= is_div_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dz_q     <= dz_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    is_div_d = is_div_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dz_d     = dz_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (bus.op_valid) begin
          case (bus.op)
            3'd4: hi_d = bus.rs_val;
            3'd5: lo_d = bus.rs_val;
            3'd0, 3'd1, 3'd2, 3'd3: begin
              if (bus.op[1] && (bus.rt_val == 32'd0)) begin
                dz_d = 1'b1;
              end else begin
                is_div_d = bus.op[1];
                sa_d     = neg_a;
                sb_d     = neg_b;
                // 0x80000000 negates to itself, which is its correct unsigned magnitude
                a_d      = neg_a ? -bus.rs_val : bus.rs_val;
                b_d      = neg_b ? -bus.rt_val : bus.rt_val;
                state_d  = ISSUE;
              end
            end
            default: ;
          endcase
        end
      end
      ISSUE: begin
        cnt_d   = CW'(TIMEOUT - 1);
        state_d = WAIT;
      end
      WAIT: begin
        if (sel_finish) begin
          res_d   = is_div_q ? {bus.div_r, bus.div_q} : bus.mul_z;
          state_d = WB;
        end else if (cnt_q == '0) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WB: begin
        if (is_div_q) begin
          lo_d = (sa_q ^ sb_q) ? -res_q[31:0] : res_q[31:0];
          hi_d = sa_q ? -res_q[63:32] : res_q[63:32];
        end else begin
          {hi_d, lo_d} = (sa_q ^ sb_q) ? -res_q : res_q;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.stall_req = (state_q != IDLE) && (bus.op_valid || bus.mf_req);
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign bus.mul_start = (state_q == ISSUE) && !is_div_q;
  assign bus.div_start = (state_q == ISSUE) && is_div_q;
  assign bus.mul_a     = is_div_q ? 32'd0 : a_q;
  assign bus.mul_b     = is_div_q ? 32'd0 : b_q;
  assign bus.div_a     = is_div_q ? a_q : 32'd0;
  assign bus.div_b     = is_div_q ? b_q : 32'd0;
  assign bus.dz_flag   = dz_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: randomized and directed checks of muldiv_ctrl against a
// signed/unsigned arithmetic reference; the bench also plays both arithmetic units.
module tb_muldiv_ctrl;
  localparam int TIMEOUT = 64;

  logic clk = 1'b0;
  logic reset;
  muldiv_if md_if ();

  muldiv_ctrl #(.TIMEOUT(TIMEOUT)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (md_if.master)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int n_mul_st = 0;
  int n_div_st = 0;
  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;

  always @(posedge clk) begin
    if (md_if.mul_start) n_mul_st++;
    if (md_if.div_start) n_div_st++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  // {hi,lo} from plain signed/unsigned arithmetic
  function automatic logic [63:0] ref_result(input logic [2:0] opc,
                                             input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (opc)
      3'd0: begin p = sa * sb; return p; end
      3'd1: return {32'd0, a} * {32'd0, b};
      3'd2: begin q = sa / sb; r = sa % sb; return {r[31:0], q[31:0]}; end
      default: return {a % b, a / b};
    endcase
  endfunction

  function automatic logic [31:0] mag(input logic sgn, input logic [31:0] v);
    return (sgn && v[31]) ? 32'd0 - v : v;
  endfunction

  task automatic drive_idle();
    md_if.op_valid   = 1'b0;
    md_if.op         = 3'd0;
    md_if.rs_val     = 32'd0;
    md_if.rt_val     = 32'd0;
    md_if.mf_req     = 1'b0;
    md_if.mul_finish = 1'b0;
    md_if.mul_z      = 64'd0;
    md_if.div_finish = 1'b0;
    md_if.div_q      = 32'd0;
    md_if.div_r      = 32'd0;
  endtask

  // Called just after a negedge with the DUT idle.
  task automatic run_op(input logic [2:0] opc, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input bit hold_mf);
    logic [63:0] r;
    logic        is_div, sgn;
    logic [31:0] ua, ub;
    int          m0, d0;
    r      = ref_result(opc, a, b);
    is_div = opc[1];
    sgn    = ~opc[0];
    m0 = n_mul_st;
    d0 = n_div_st;
    md_if.op_valid = 1'b1; md_if.op = opc; md_if.rs_val = a; md_if.rt_val = b;
    md_if.mf_req = hold_mf;
    #1 chk("idle_no_stall", md_if.stall_req, 1'b0);
    @(negedge clk);
    md_if.op_valid = 1'b0;
    chk("issue_busy", md_if.busy, 1'b1);
    chk("issue_mul_start", md_if.mul_start, !is_div);
    chk("issue_div_start", md_if.div_start, is_div);
    ua = is_div ? md_if.div_a : md_if.mul_a;
    ub = is_div ? md_if.div_b : md_if.mul_b;
    chk("issue_opa", ua, mag(sgn, a));
    chk("issue_opb", ub, mag(sgn, b));
    #1 chk("issue_stall", md_if.stall_req, hold_mf);
    for (int i = 1; i <= lat; i++) begin
      @(negedge clk);
      md_if.mul_finish = 1'b0;
      md_if.div_finish = 1'b0;
      if (i == lat) begin
        chk("wait_opa_stable", is_div ? md_if.div_a : md_if.mul_a, mag(sgn, a));
        if (is_div) begin
          md_if.div_finish = 1'b1; md_if.div_q = ua / ub; md_if.div_r = ua % ub;
        end else begin
          md_if.mul_finish = 1'b1; md_if.mul_z = {32'd0, ua} * {32'd0, ub};
        end
      end else if (i == 1) begin
        // decoy finish from the unit that was not started
        if (is_div) begin md_if.mul_finish = 1'b1; md_if.mul_z = {$urandom, $urandom}; end
        else begin md_if.div_finish = 1'b1; md_if.div_q = $urandom; md_if.div_r = $urandom; end
      end
      #1 chk("wait_stall", md_if.stall_req, hold_mf);
    end
    @(negedge clk);
    md_if.mul_finish = 1'b0;
    md_if.div_finish = 1'b0;
    chk("wb_busy", md_if.busy, 1'b1);
    #1 chk("wb_stall", md_if.stall_req, hold_mf);
    @(negedge clk);
    exp_hi = r[63:32];
    exp_lo = r[31:0];
    chk("done_busy", md_if.busy, 1'b0);
    chk("done_stall", md_if.stall_req, 1'b0);
    chk("done_hi", md_if.hi, exp_hi);
    chk("done_lo", md_if.lo, exp_lo);
    chk("mul_start_count", n_mul_st - m0, is_div ? 0 : 1);
    chk("div_start_count", n_div_st - d0, is_div ? 1 : 0);
    md_if.mf_req = 1'b0;
  endtask

  task automatic run_mt(input logic [2:0] opc, input logic [31:0] v);
    md_if.op_valid = 1'b1; md_if.op = opc; md_if.rs_val = v;
    #1 chk("mt_no_stall", md_if.stall_req, 1'b0);
    @(negedge clk);
    md_if.op_valid = 1'b0;
    if (opc == 3'd4) exp_hi = v;
    if (opc == 3'd5) exp_lo = v;
    chk("mt_busy", md_if.busy, 1'b0);
    chk("mt_hi", md_if.hi, exp_hi);
    chk("mt_lo", md_if.lo, exp_lo);
  endtask

  initial begin
    int m0, d0, n;
    logic [2:0]  opc;
    logic [31:0] a, b;
    reset = 1'b1;
    drive_idle();
    @(negedge clk);
    chk("rst_hi", md_if.hi, 32'd0);
    chk("rst_lo", md_if.lo, 32'd0);
    chk("rst_busy", md_if.busy, 1'b0);
    chk("rst_starts", {md_if.mul_start, md_if.div_start}, 2'b00);
    chk("rst_ops", {md_if.mul_a, md_if.mul_b, md_if.div_a, md_if.div_b}, 128'd0);
    chk("rst_flags", {md_if.dz_flag, md_if.err}, 2'b00);
    reset = 1'b0;
    @(negedge clk);

    run_op(3'd0, 32'hFFFFFFFD, 32'd5, 3, 1'b0);
    chk("mult_neg3x5", {md_if.hi, md_if.lo}, 64'hFFFFFFFF_FFFFFFF1);
    run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 1'b1);
    chk("multu_max", {md_if.hi, md_if.lo}, 64'hFFFFFFFE_00000001);
    run_op(3'd2, 32'hFFFFFFF9, 32'd2, 2, 1'b0);
    chk("div_neg7_2", {md_if.hi, md_if.lo}, 64'hFFFFFFFF_FFFFFFFD);
    run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 4, 1'b1);
    chk("div_ovf", {md_if.hi, md_if.lo}, 64'h00000000_80000000);

    run_mt(3'd4, 32'h11);
    run_mt(3'd5, 32'h22);
    m0 = n_mul_st; d0 = n_div_st;
    chk("dz_pre", md_if.dz_flag, 1'b0);
    md_if.op_valid = 1'b1; md_if.op = 3'd3; md_if.rs_val = 32'd100; md_if.rt_val = 32'd0;
    @(negedge clk);
    md_if.op_valid = 1'b0;
    chk("dz_flag", md_if.dz_flag, 1'b1);
    chk("dz_busy", md_if.busy, 1'b0);
    @(negedge clk);
    chk("dz_busy2", md_if.busy, 1'b0);
    chk("dz_hilo", {md_if.hi, md_if.lo}, 64'h00000011_00000022);
    chk("dz_no_start", (n_mul_st - m0) + (n_div_st - d0), 0);

    run_mt(3'd5, 32'h1234);
    md_if.op_valid = 1'b1; md_if.op = 3'd6; md_if.rs_val = 32'hDEAD;
    @(negedge clk);
    md_if.op_valid = 1'b0;
    chk("op6_busy", md_if.busy, 1'b0);
    chk("op6_hilo", {md_if.hi, md_if.lo}, {exp_hi, exp_lo});

    for (int k = 0; k < 30; k++) begin
      opc = 3'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 2) == 0) b = $urandom_range(0, 9) ^ {32{b[31]}};
      if (opc[1] && b == 32'd0) b = 32'd1;
      run_op(opc, a, b, int'($urandom_range(1, 6)), 1'($urandom_range(0, 1)));
    end
    chk("rand_err_clear", md_if.err, 1'b0);

    // multiplier never answers
    md_if.op_valid = 1'b1; md_if.op = 3'd1; md_if.rs_val = 32'd7; md_if.rt_val = 32'd9;
    @(negedge clk);
    md_if.op_valid = 1'b0;
    chk("to_start", md_if.mul_start, 1'b1);
    n = 0;
    while (md_if.busy && n < 4 * TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    chk("to_cycles", n, TIMEOUT + 1);
    chk("to_err", md_if.err, 1'b1);
    chk("to_hilo", {md_if.hi, md_if.lo}, {exp_hi, exp_lo});

    // reset in WAIT
    md_if.op_valid = 1'b1; md_if.op = 3'd0; md_if.rs_val = 32'd3; md_if.rt_val = 32'd4;
    @(negedge clk);
    md_if.op_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_wait_busy_pre", md_if.busy, 1'b1);
    reset = 1'b1;
    #1;
    chk("rstw_busy", md_if.busy, 1'b0);
    chk("rstw_hilo", {md_if.hi, md_if.lo}, 64'd0);
    chk("rstw_start", md_if.mul_start, 1'b0);
    chk("rstw_err", md_if.err, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    md_if.mul_finish = 1'b1; md_if.mul_z = 64'h1234_5678_9ABC_DEF0;
    @(negedge clk);
    md_if.mul_finish = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("late_fin_hilo", {md_if.hi, md_if.lo}, 64'd0);
    chk("late_fin_busy", md_if.busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
